// File: rtl/mult32x32_ctrl.sv
// Sequencing controller for the 32x32->64 sequential multiplier: captures the
// operands and steps mult32x32_arith through the four 16x16 partial products.
module mult32x32_ctrl #(
    parameter int unsigned ZERO_SKIP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] op_a, op_b;
    logic [3:0]  skip;

    function automatic state_t pp_of(input logic [1:0] idx);
        state_t s;
        case (idx)
            2'd0:    s = S_PP0;
            2'd1:    s = S_PP1;
            2'd2:    s = S_PP2;
            default: s = S_PP3;
        endcase
        return s;
    endfunction

    // First non-skipped step at or after index 'first', else DONE.
    function automatic state_t next_step(input int unsigned first, input logic [3:0] skp);
        state_t nxt;
        logic   found;
        nxt   = S_DONE;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && i >= first && !skp[i]) begin
                found = 1'b1;
                nxt   = pp_of(i[1:0]);
            end
        end
        return nxt;
    endfunction

    always_comb begin
        // Leaving IDLE the operands are not yet captured, so look at the inputs.
        op_a    = (state_q == S_IDLE) ? a_in : a_q;
        op_b    = (state_q == S_IDLE) ? b_in : b_q;
        skip[0] = (ZERO_SKIP != 0) && (op_a[15:0]  == '0 || op_b[15:0]  == '0);
        skip[1] = (ZERO_SKIP != 0) && (op_a[15:0]  == '0 || op_b[31:16] == '0);
        skip[2] = (ZERO_SKIP != 0) && (op_a[31:16] == '0 || op_b[15:0]  == '0);
        skip[3] = (ZERO_SKIP != 0) && (op_a[31:16] == '0 || op_b[31:16] == '0);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        shift_sel = 2'b11;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr_prod = start;
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = next_step(0, skip);
                end
            end
            S_PP0: begin
                busy      = 1'b1;
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b00;
                upd_prod  = 1'b1;
                state_d   = next_step(1, skip);
            end
            S_PP1: begin
                busy      = 1'b1;
                a_sel     = 1'b1;
                shift_sel = 2'b01;
                upd_prod  = 1'b1;
                state_d   = next_step(2, skip);
            end
            S_PP2: begin
                busy      = 1'b1;
                b_sel     = 1'b1;
                shift_sel = 2'b01;
                upd_prod  = 1'b1;
                state_d   = next_step(3, skip);
            end
            S_PP3: begin
                busy      = 1'b1;
                shift_sel = 2'b10;
                upd_prod  = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a = a_q;
    assign b = b_q;

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Directed bench: two controllers (ZERO_SKIP=0 and 1), each driving a
// behavioural model of the arith unit that accumulates the selected products.
module tb_mult32x32_ctrl;

    logic        clk = 1'b0;
    logic        reset;

    logic        start0, start1;
    logic [31:0] a_in0, b_in0, a_in1, b_in1;
    logic [31:0] a0, b0, a1, b1;
    logic        a_sel0, b_sel0, upd0, clr0, busy0, done0;
    logic        a_sel1, b_sel1, upd1, clr1, busy1, done1;
    logic [1:0]  shift0, shift1;
    logic [63:0] prod0, prod1;

    int tests = 0;
    int fails = 0;

    localparam logic [4:0] CV_IDLE = 5'b00110;
    localparam logic [4:0] CV_PP0  = 5'b11001;
    localparam logic [4:0] CV_PP1  = 5'b10011;
    localparam logic [4:0] CV_PP2  = 5'b01011;
    localparam logic [4:0] CV_PP3  = 5'b00101;

    always #5 clk = ~clk;

    mult32x32_ctrl #(.ZERO_SKIP(0)) u_ctrl (
        .clk(clk), .reset(reset), .start(start0), .a_in(a_in0), .b_in(b_in0),
        .a(a0), .b(b0), .a_sel(a_sel0), .b_sel(b_sel0), .shift_sel(shift0),
        .upd_prod(upd0), .clr_prod(clr0), .busy(busy0), .done(done0)
    );

    mult32x32_ctrl #(.ZERO_SKIP(1)) u_ctrl_zs (
        .clk(clk), .reset(reset), .start(start1), .a_in(a_in1), .b_in(b_in1),
        .a(a1), .b(b1), .a_sel(a_sel1), .b_sel(b_sel1), .shift_sel(shift1),
        .upd_prod(upd1), .clr_prod(clr1), .busy(busy1), .done(done1)
    );

    function automatic logic [63:0] pp_term(input logic [31:0] a, input logic [31:0] b,
                                            input logic as, input logic bs,
                                            input logic [1:0] sh);
        logic [63:0] ha, hb, m;
        ha = as ? {48'd0, a[15:0]} : {48'd0, a[31:16]};
        hb = bs ? {48'd0, b[15:0]} : {48'd0, b[31:16]};
        m  = ha * hb;
        case (sh)
            2'b00:   return m;
            2'b01:   return m << 16;
            2'b10:   return m << 32;
            default: return 64'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     prod0 <= '0;
        else if (clr0) prod0 <= '0;
        else if (upd0) prod0 <= prod0 + pp_term(a0, b0, a_sel0, b_sel0, shift0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     prod1 <= '0;
        else if (clr1) prod1 <= '0;
        else if (upd1) prod1 <= prod1 + pp_term(a1, b1, a_sel1, b_sel1, shift1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int          busy_cnt;
        logic [63:0] prod_at_done;
        logic        exp_busy, exp_done;

        reset  = 1'b1;
        start0 = 1'b0; a_in0 = '0; b_in0 = '0;
        start1 = 1'b0; a_in1 = '0; b_in1 = '0;
        tick;
        tick;
        chk("rst_ctrl", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_IDLE});
        chk("rst_a", {32'd0, a0}, 64'd0);
        chk("rst_b", {32'd0, b0}, 64'd0);
        chk("rst_flags", {61'd0, clr0, busy0, done0}, 64'd0);
        reset = 1'b0;
        tick;

        // 1: step sequence and latency
        a_in0 = 32'h00010002; b_in0 = 32'h00030004; start0 = 1'b1;
        #1;
        chk("t1_clr", {63'd0, clr0}, 64'd1);
        tick; start0 = 1'b0;
        chk("t1_pp0", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_PP0});
        chk("t1_a", {32'd0, a0}, 64'h00010002);
        tick;
        chk("t1_pp1", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_PP1});
        tick;
        chk("t1_pp2", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_PP2});
        tick;
        chk("t1_pp3", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_PP3});
        chk("t1_nodone", {63'd0, done0}, 64'd0);
        tick;
        chk("t1_done", {63'd0, done0}, 64'd1);
        chk("t1_prod", prod0, 64'h00000003000A0008);
        chk("t1_done_ctrl", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_IDLE});
        tick;
        chk("t1_idle", {62'd0, busy0, done0}, 64'd0);

        // 2: all-ones operands, busy for exactly five cycles
        a_in0 = 32'hFFFFFFFF; b_in0 = 32'hFFFFFFFF; start0 = 1'b1;
        busy_cnt = 0; prod_at_done = '0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i == 0) start0 = 1'b0;
            busy_cnt += int'(busy0);
            if (done0) prod_at_done = prod0;
        end
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd5);
        chk("t2_prod", prod_at_done, 64'hFFFFFFFE00000001);

        // 3: start held high -> back-to-back ops with a 6-cycle period
        a_in0 = 32'd7; b_in0 = 32'd9; start0 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick;
            exp_busy = !(i == 6 || i == 12);
            exp_done = (i == 5 || i == 11);
            chk($sformatf("t3_busy_%0d", i), {63'd0, busy0}, {63'd0, exp_busy});
            chk($sformatf("t3_done_%0d", i), {63'd0, done0}, {63'd0, exp_done});
            if (exp_done) chk($sformatf("t3_prod_%0d", i), prod0, 64'd63);
        end
        chk("t3_reaccept_clr", {63'd0, clr0}, 64'd1);
        start0 = 1'b0;
        tick;

        // 4: reset during PP2 aborts, then a fresh op
        a_in0 = 32'h12345678; b_in0 = 32'h9ABCDEF0; start0 = 1'b1;
        tick; start0 = 1'b0;
        tick;
        tick;
        chk("t4_in_pp2", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_PP2});
        reset = 1'b1;
        #1;
        chk("t4_busy", {63'd0, busy0}, 64'd0);
        chk("t4_done", {63'd0, done0}, 64'd0);
        chk("t4_prod", prod0, 64'd0);
        chk("t4_a", {32'd0, a0}, 64'd0);
        chk("t4_ctrl", {59'd0, a_sel0, b_sel0, shift0, upd0}, {59'd0, CV_IDLE});
        tick;
        reset = 1'b0;
        tick;
        chk("t4_still_idle", {62'd0, busy0, done0}, 64'd0);
        a_in0 = 32'd3; b_in0 = 32'd5; start0 = 1'b1;
        tick; start0 = 1'b0;
        tick; tick; tick; tick;
        chk("t4_done2", {63'd0, done0}, 64'd1);
        chk("t4_prod2", prod0, 64'd15);
        tick;

        // 5: zero-skip instance
        a_in1 = 32'h0000FFFF; b_in1 = 32'h0000FFFF; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("t5_pp0", {59'd0, a_sel1, b_sel1, shift1, upd1}, {59'd0, CV_PP0});
        tick;
        chk("t5_done", {63'd0, done1}, 64'd1);
        chk("t5_prod", prod1, 64'h00000000FFFE0001);
        tick;
        a_in1 = 32'h00000000; b_in1 = 32'h12345678; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("t5_zero_done", {62'd0, busy1, done1}, 64'd3);
        chk("t5_zero_prod", prod1, 64'd0);
        tick;
        a_in1 = 32'h00010000; b_in1 = 32'h00000001; start1 = 1'b1;
        tick; start1 = 1'b0;
        chk("t5_only_pp2", {59'd0, a_sel1, b_sel1, shift1, upd1}, {59'd0, CV_PP2});
        tick;
        chk("t5_hl_done", {63'd0, done1}, 64'd1);
        chk("t5_hl_prod", prod1, 64'h0000000000010000);
        tick;

        // 6: inputs wiggle while busy
        a_in0 = 32'h00010002; b_in0 = 32'h00030004; start0 = 1'b1;
        tick; start0 = 1'b0;
        a_in0 = 32'hDEADBEEF; b_in0 = 32'hCAFEF00D;
        tick;
        a_in0 = 32'h00000000; b_in0 = 32'hFFFFFFFF;
        tick;
        tick;
        chk("t6_a", {32'd0, a0}, 64'h00010002);
        chk("t6_b", {32'd0, b0}, 64'h00030004);
        tick;
        chk("t6_done", {63'd0, done0}, 64'd1);
        chk("t6_prod", prod0, 64'h00000003000A0008);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
